// File: rtl/ser_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg
//   Shared definitions for the stream serializer slice.
//   - ser_cnt_w()  : width of the per-frame word-count field for a given
//                    frame/word width pair (enough bits to hold N_WORDS).
//   - ser_state_e  : shift-stage state encoding.
//   The frame record (data, nwords, msb_first) depends on module parameters,
//   so it is declared as a packed struct inside the top module.
// ---------------------------------------------------------------------------
package ser_pkg;

  function automatic int ser_cnt_w(input int in_w, input int out_w);
    return $clog2(in_w / out_w + 1);
  endfunction

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/ser_pend_buf.sv
// ---------------------------------------------------------------------------
// ser_pend_buf
//   Single-entry frame holding register. A push loads din and marks the entry
//   valid; a pop releases it. The owner never pushes while the entry is valid
//   (ready is low then), so push and pop are mutually exclusive in practice;
//   push is still given priority for safety.
//   ready is registered and is simply the inverse of the held-valid flag.
// Ports
//   clk, reset : clock, synchronous active-high flush of the entry
//   push, din  : load a frame
//   pop        : release the held frame
//   dout       : held frame contents
//   valid      : entry holds a frame
//   ready      : entry is empty (frame may be pushed)
// ---------------------------------------------------------------------------
module ser_pend_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         ready
);

  logic [W-1:0] data_r;
  logic         valid_r;
  logic         ready_r;

  // Entry storage and its valid/ready flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r  <= '0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else if (push) begin
      data_r  <= din;
      valid_r <= 1'b1;
      ready_r <= 1'b0;
    end else if (pop) begin
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      valid_r <= valid_r;
      ready_r <= ready_r;
    end
  end

  assign dout  = data_r;
  assign valid = valid_r;
  assign ready = ready_r;

endmodule

// File: rtl/stream_serializer.sv
// ---------------------------------------------------------------------------
// stream_serializer
//   Splits an IN_W-bit frame into up to N_WORDS = IN_W/OUT_W words of OUT_W
//   bits, with valid/ready handshakes on both sides. Each frame carries its
//   own word count (0 or >N_WORDS means all words) and word order
//   (msb_first=1 starts at word N_WORDS-1 and counts down).
//   A shift stage holds the active frame; a one-entry pending stage holds the
//   next frame so back-to-back frames run with no idle cycle between them.
// Optional feature
//   `define STREAM_SER_LAST_EN adds the registered out_last port, high on the
//   final word of every frame.
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_nwords/in_msb_first : frame input
//   out_valid/out_ready/out_data : word output
//   busy         : a word is being offered or a frame is pending
//   out_last     : (STREAM_SER_LAST_EN only) final word of the frame
// ---------------------------------------------------------------------------
module stream_serializer
  import ser_pkg::*;
#(
  parameter int IN_W  = 24,
  parameter int OUT_W = 8,
  parameter int CNT_W = ser_cnt_w(IN_W, OUT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [CNT_W-1:0] in_nwords,
  input  logic             in_msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy
`ifdef STREAM_SER_LAST_EN
  ,
  output logic             out_last
`endif
);

  localparam int N_WORDS = IN_W / OUT_W;
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [CNT_W-1:0] N_WORDS_C = CNT_W'(N_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(0);
  localparam logic [IDX_W-1:0] IDX_TOP_C = IDX_W'(N_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE_C = IDX_W'(1);

  typedef struct packed {
    logic [IN_W-1:0]  data;
    logic [CNT_W-1:0] nwords;
    logic             msb_first;
  } frame_t;

  localparam int FRAME_W = $bits(frame_t);

  // Parameter sanity: frame must be a whole number of words, count width fixed.
  if ((IN_W % OUT_W) != 0 || IN_W < OUT_W || CNT_W != ser_cnt_w(IN_W, OUT_W)) begin : g_param_check
    $error("stream_serializer: IN_W must be a positive multiple of OUT_W and CNT_W must not be overridden");
  end

  // Word k of a frame sits at bits [(k+1)*OUT_W-1 -: OUT_W].
  function automatic logic [OUT_W-1:0] word_at(input logic [IN_W-1:0] d,
                                               input logic [IDX_W-1:0] idx);
    logic [OUT_W-1:0] w;
    w = '0;
    for (int k = 0; k < N_WORDS; k++) begin
      if (idx == IDX_W'(k)) begin
        w = d[k*OUT_W +: OUT_W];
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // Shift-stage registers.
  ser_state_e       state_r;
  logic [IN_W-1:0]  data_r;
  logic             msb_r;
  logic [IDX_W-1:0] idx_r;
  logic [CNT_W-1:0] rem_r;
  logic             out_valid_r;
  logic [OUT_W-1:0] out_data_r;
  logic             busy_r;
`ifdef STREAM_SER_LAST_EN
  logic             last_r;
`endif

  // Combinational control.
  frame_t           in_frame_s;
  frame_t           pend_frame_s;
  frame_t           load_frame_s;
  logic             pend_valid_s;
  logic             pend_ready_s;
  logic             accept_s;
  logic             fire_s;
  logic             finish_s;
  logic             push_s;
  logic             pop_s;
  logic             load_s;
  logic [CNT_W-1:0] ld_cnt_s;
  logic [IDX_W-1:0] ld_idx_s;
  logic [IDX_W-1:0] adv_idx_s;
  logic [CNT_W-1:0] adv_rem_s;
  logic             out_valid_nxt_s;
  logic             pend_valid_nxt_s;

  assign in_frame_s.data      = in_data;
  assign in_frame_s.nwords    = in_nwords;
  assign in_frame_s.msb_first = in_msb_first;

  ser_pend_buf #(
    .W (FRAME_W)
  ) u_pend_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (in_frame_s),
    .dout  (pend_frame_s),
    .valid (pend_valid_s),
    .ready (pend_ready_s)
  );

  assign accept_s = in_valid && pend_ready_s;
  assign fire_s   = out_valid_r && out_ready;
  assign finish_s = fire_s && (rem_r == CNT_ONE_C);

  // Choose what happens to the shift and pending stages this cycle.
  // The pending frame always wins over a newly offered one; the offered frame
  // bypasses pending only when the shift stage is free at the edge.
  always_comb begin
    push_s       = 1'b0;
    pop_s        = 1'b0;
    load_s       = 1'b0;
    load_frame_s = in_frame_s;
    case (state_r)
      SER_IDLE: begin
        if (pend_valid_s) begin
          pop_s        = 1'b1;
          load_s       = 1'b1;
          load_frame_s = pend_frame_s;
        end else if (accept_s) begin
          load_s       = 1'b1;
        end else begin
          load_s       = 1'b0;
        end
      end
      SER_SHIFT: begin
        if (finish_s) begin
          if (pend_valid_s) begin
            pop_s        = 1'b1;
            load_s       = 1'b1;
            load_frame_s = pend_frame_s;
          end else if (accept_s) begin
            load_s       = 1'b1;
          end else begin
            load_s       = 1'b0;
          end
        end else if (accept_s) begin
          push_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Start point of a newly loaded frame and the next step of the active one.
  always_comb begin
    if (load_frame_s.nwords == CNT_ZERO_C || load_frame_s.nwords > N_WORDS_C) begin
      ld_cnt_s = N_WORDS_C;
    end else begin
      ld_cnt_s = load_frame_s.nwords;
    end
    if (load_frame_s.msb_first) begin
      ld_idx_s = IDX_TOP_C;
    end else begin
      ld_idx_s = '0;
    end
    if (msb_r) begin
      adv_idx_s = idx_r - IDX_ONE_C;
    end else begin
      adv_idx_s = idx_r + IDX_ONE_C;
    end
    adv_rem_s        = rem_r - CNT_ONE_C;
    out_valid_nxt_s  = load_s ? 1'b1 : (finish_s ? 1'b0 : out_valid_r);
    pend_valid_nxt_s = push_s || (pend_valid_s && !pop_s);
  end

  // Shift-stage FSM with registered word, valid, busy and last outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= SER_IDLE;
      data_r      <= '0;
      msb_r       <= 1'b0;
      idx_r       <= '0;
      rem_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      busy_r      <= 1'b0;
`ifdef STREAM_SER_LAST_EN
      last_r      <= 1'b0;
`endif
    end else begin
      busy_r <= out_valid_nxt_s || pend_valid_nxt_s;
      if (load_s) begin
        state_r     <= SER_SHIFT;
        data_r      <= load_frame_s.data;
        msb_r       <= load_frame_s.msb_first;
        idx_r       <= ld_idx_s;
        rem_r       <= ld_cnt_s;
        out_valid_r <= 1'b1;
        out_data_r  <= word_at(load_frame_s.data, ld_idx_s);
`ifdef STREAM_SER_LAST_EN
        last_r      <= (ld_cnt_s == CNT_ONE_C);
`endif
      end else if (finish_s) begin
        state_r     <= SER_IDLE;
        rem_r       <= '0;
        out_valid_r <= 1'b0;
`ifdef STREAM_SER_LAST_EN
        last_r      <= 1'b0;
`endif
      end else if (fire_s) begin
        idx_r       <= adv_idx_s;
        rem_r       <= adv_rem_s;
        out_data_r  <= word_at(data_r, adv_idx_s);
`ifdef STREAM_SER_LAST_EN
        last_r      <= (adv_rem_s == CNT_ONE_C);
`endif
      end else begin
        state_r     <= state_r;
      end
    end
  end

  assign in_ready  = pend_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;
`ifdef STREAM_SER_LAST_EN
  assign out_last  = last_r;
`endif

endmodule

// File: tb/tb_stream_serializer.sv
// ---------------------------------------------------------------------------
// tb_stream_serializer
//   Scoreboard bench for stream_serializer (IN_W=24, OUT_W=8). Each accepted
//   frame is expanded by a reference model into its expected word list; a
//   monitor compares every output handshake against it and also checks
//   valid/busy/in_ready occupancy, stall stability and zero-bubble behaviour.
// ---------------------------------------------------------------------------
module tb_stream_serializer;

  localparam int IN_W  = 24;
  localparam int OUT_W = 8;
  localparam int NW    = 3;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [CNT_W-1:0] in_nwords;
  logic             in_msb_first;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             busy;
`ifdef STREAM_SER_LAST_EN
  logic             out_last;
`endif

  always #5 clk = ~clk;

  stream_serializer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_nwords    (in_nwords),
    .in_msb_first (in_msb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy)
`ifdef STREAM_SER_LAST_EN
    ,
    .out_last     (out_last)
`endif
  );

  typedef struct {
    logic [OUT_W-1:0] w;
    bit               last;
  } exp_t;

  exp_t exp_q[$];
  int   frame_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: list the words a frame should produce.
  task automatic model_accept(input logic [IN_W-1:0] d, input int nw, input bit msb);
    int n;
    int idx;
    logic [IN_W-1:0] sh;
    exp_t e;
    n = (nw == 0 || nw > NW) ? NW : nw;
    for (int j = 0; j < n; j++) begin
      idx    = msb ? (NW - 1 - j) : j;
      sh     = d >> (OUT_W * idx);
      e.w    = sh[OUT_W-1:0];
      e.last = (j == n - 1);
      exp_q.push_back(e);
    end
    frame_q.push_back(n);
  endtask

  // Monitor: outputs are stable between the edges, so sample on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      frame_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      chk("busy", {31'd0, busy}, {31'd0, exp_q.size() > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, frame_q.size() < 2});
      if (prev_stall) chk("stall_hold", {24'd0, out_data}, {24'd0, prev_data});
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("word", {24'd0, out_data}, {24'd0, e.w});
`ifdef STREAM_SER_LAST_EN
        chk("out_last", {31'd0, out_last}, {31'd0, e.last});
`endif
        frame_q[0] = frame_q[0] - 1;
        if (frame_q[0] == 0) void'(frame_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (in_valid && in_ready) model_accept(in_data, int'(in_nwords), in_msb_first);
    end
  end

  // Offer a frame until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [IN_W-1:0] d, input logic [CNT_W-1:0] nw, input logic msb);
    bit acc;
    bit done;
    done         = 1'b0;
    in_valid     = 1'b1;
    in_data      = d;
    in_nwords    = nw;
    in_msb_first = msb;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      done = acc;
    end
    if (!done) chk("in_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = !out_valid && !busy;
    end
    chk("idle_timeout", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  v;
    bit  acc;
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_nwords    = '0;
    in_msb_first = 1'b0;
    out_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Full frame MSB-first, first word one clock after accept.
    send(24'hAABBCC, 2'd0, 1'b1);
    chk("t1_first_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_first_word", {24'd0, out_data}, 32'h0000_00AA);
    wait_idle();

    // LSB-first partial frame, then explicit full count.
    send(24'hAABBCC, 2'd2, 1'b0);
    chk("t2_first_word", {24'd0, out_data}, 32'h0000_00CC);
    wait_idle();
    send(24'hAABBCC, 2'd3, 1'b0);
    wait_idle();

    // Back-to-back frames: five more valid cycles after the second accept.
    send(24'h010203, 2'd0, 1'b1);
    send(24'h040506, 2'd0, 1'b1);
    v = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) v++;
      else break;
    end
    chk("t3_consecutive", v, 32'd5);
    @(posedge clk);
    #1;
    wait_idle();

    // Output stalls in the middle of a frame.
    send(24'h112233, 2'd0, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("t4_stall1", {24'd0, out_data}, 32'h0000_0022);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t4_stall2", {24'd0, out_data}, 32'h0000_0022);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();

    // Reset with a frame in flight and another pending.
    send(24'h123456, 2'd0, 1'b1);
    send(24'h654321, 2'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_out_data", {24'd0, out_data}, 32'd0);
    @(posedge clk);
    #1;
    send(24'h0A0B0C, 2'd0, 1'b1);
    chk("t5_first_word", {24'd0, out_data}, 32'h0000_000A);
    wait_idle();

    // Single-word frame followed by a full frame.
    send(24'hA1A2A3, 2'd1, 1'b1);
    send(24'hB1B2B3, 2'd3, 1'b0);
    wait_idle();

    // Randomised traffic with random back-pressure.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc || !in_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          in_valid     = 1'b1;
          in_data      = IN_W'($urandom());
          in_nwords    = CNT_W'($urandom_range(0, 3));
          in_msb_first = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
